// File: rtl/alu_pkg.sv
// Shared opcode encodings and shifter FSM states for the sequential ALU.
// The ALU_BARREL_SHIFT_EN build leaves the shift state type unused.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative left shifter: one bit per cycle, with a finish strobe on the last shift edge.
// It is not instantiated when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [SH_W-1:0]  load_amt,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  localparam logic [SH_W-1:0] CNT_ONE = SH_W'(1);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shreg_d = load_data;
          cnt_d   = load_amt;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CNT_ONE;
        // The edge that performs the final shift also retires the result.
        if (cnt_q == CNT_ONE) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q == ST_SHIFT);
  assign result = shreg_q << 1;

endmodule

// File: rtl/alu_seq.sv
// Registered 8-operation ALU with iterative SLL and an LED byte view of the result.
// Define ALU_BARREL_SHIFT_EN to make SLL single-cycle (no busy, no shift FSM).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       F_LED_SW,
  output logic [WIDTH-1:0] F,
  output logic             OF,
  output logic             ZF,
  output logic             busy,
  output logic             done,
  output logic [7:0]       LED
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] f_q, f_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum, diff, op_res, sh_result;
  logic             op_of, slt, accept, sh_load, sh_finish, busy_w;

  assign shamt  = A[SH_W-1:0];
  assign sum    = A + B;
  assign diff   = A - B;
  assign slt    = $signed(A) < $signed(B);
  assign accept = start & ~busy_w;

`ifdef ALU_BARREL_SHIFT_EN
  assign busy_w    = 1'b0;
  assign sh_load   = 1'b0;
  assign sh_finish = 1'b0;
  assign sh_result = '0;
`else
  assign sh_load = accept && (ALU_OP == OP_SLL) && (shamt != '0);

  alu_shift_unit #(
    .WIDTH(WIDTH),
    .SH_W (SH_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_data(B),
    .load_amt (shamt),
    .busy     (busy_w),
    .finish   (sh_finish),
    .result   (sh_result)
  );
`endif

  always_comb begin
    op_res = '0;
    op_of  = 1'b0;
    case (ALU_OP)
      OP_AND: op_res = A & B;
      OP_OR:  op_res = A | B;
      OP_XOR: op_res = A ^ B;
      OP_NOR: op_res = ~(A | B);
      OP_ADD: begin
        op_res = sum;
        op_of  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_of  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL: op_res = B << shamt;
      default: op_res = '0;
    endcase
  end

  // F and flags move only on an edge that also raises done.
  always_comb begin
    f_d    = f_q;
    of_d   = of_q;
    zf_d   = zf_q;
    done_d = 1'b0;
    if (sh_finish) begin
      f_d    = sh_result;
      of_d   = 1'b0;
      zf_d   = (sh_result == '0);
      done_d = 1'b1;
    end else if (accept && !sh_load) begin
      f_d    = op_res;
      of_d   = op_of;
      zf_d   = (op_res == '0);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q    <= '0;
      of_q   <= 1'b0;
      zf_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      of_q   <= of_d;
      zf_q   <= zf_d;
      done_q <= done_d;
    end
  end

  // Byte lanes beyond WIDTH/8 read as zero.
  logic [7:0] led_bytes [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_led
    if (gi < WIDTH / 8) begin : g_on
      assign led_bytes[gi] = f_q[8*gi +: 8];
    end else begin : g_off
      assign led_bytes[gi] = 8'h00;
    end
  end

  assign LED  = led_bytes[F_LED_SW];
  assign F    = f_q;
  assign OF   = of_q;
  assign ZF   = zf_q;
  assign busy = busy_w;
  assign done = done_q;

endmodule
